// File: rtl/vga_vram_arbiter.sv
// ---------------------------------------------------------------------------
// vga_vram_arbiter
//
// Shares one single-port video RAM between the VGA scanout fetch path and the
// AVR CPU bus. Video reads normally win; a starvation counter forces a CPU
// slot after STARVE consecutive video-won cycles with the CPU waiting. Video
// requests are buffered in a 2-entry FIFO so a CPU slot delays rather than
// drops them.
//
// Timeline for a slot decided in cycle N:
//   N   : slot chosen from registered FIFO / arbiter state
//   N+1 : mem_addr / mem_we / mem_wdata driven (registered)
//   N+2 : mem_rdata valid from the VRAM, captured at the end of the cycle
//   N+3 : vid_valid or cpu_ack pulses with the captured data
//
// Optional feature (compile-time macro VGA_ARB_STATS_EN):
//   defined     -> stat_wait counts CPU-denied cycles, saturating at 0xFFFF
//   not defined -> stat_wait is tied to 0 and no counter exists
//
// Ports:
//   clock      system clock
//   reset_n    synchronous, active-low reset
//   vid_req    one-cycle pulse requesting a video read of vid_addr
//   vid_addr   video read address
//   vid_valid  one-cycle pulse, vid_rdata valid
//   vid_rdata  video read data (held until the next vid_valid)
//   vid_ovf    sticky flag: a video request was dropped (FIFO full)
//   cpu_req    CPU request level, held until cpu_ack
//   cpu_we     1 = write, 0 = read
//   cpu_addr   CPU address
//   cpu_wdata  CPU write data
//   cpu_ack    one-cycle pulse, CPU op complete
//   cpu_rdata  CPU read data (updated on read acks only)
//   mem_addr   VRAM address (registered)
//   mem_we     VRAM write strobe (registered)
//   mem_wdata  VRAM write data (registered)
//   mem_rdata  VRAM read data, valid the cycle after mem_addr
//   stat_wait  CPU wait statistic
// ---------------------------------------------------------------------------
module vga_vram_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int STARVE = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_ovf,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stat_wait
);

    // Width of the starvation counter; it never needs to exceed STARVE.
    localparam int SW = $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    // Slot kinds chosen each cycle.
    localparam logic [1:0] SLOT_IDLE = 2'd0;
    localparam logic [1:0] SLOT_VID  = 2'd1;
    localparam logic [1:0] SLOT_CPU  = 2'd2;

    // Video FIFO state
    logic [AW-1:0] fifo_mem_r [0:1];
    logic          rd_ptr_r;
    logic          wr_ptr_r;
    logic [1:0]    fifo_cnt_r;
    logic [1:0]    fifo_cnt_nxt_s;

    // Arbiter state
    logic [SW-1:0] starve_r;
    logic          pending_r;

    // Issue / return pipeline tracking
    logic          iss_vld_r;
    logic          iss_cpu_r;
    logic          ret_vld_r;
    logic          ret_cpu_r;
    logic          ret_we_r;

    // Output registers
    logic [AW-1:0] mem_addr_r;
    logic          mem_we_r;
    logic [DW-1:0] mem_wdata_r;
    logic          vid_valid_r;
    logic [DW-1:0] vid_rdata_r;
    logic          vid_ovf_r;
    logic          cpu_ack_r;
    logic [DW-1:0] cpu_rdata_r;

    // Combinational decision signals
    logic          cpu_elig_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          starved_s;
    logic [1:0]    slot_s;
    logic          pop_s;
    logic          push_ok_s;
    logic          drop_s;

    // Slot decision from registered FIFO and arbiter state only
    always_comb begin
        cpu_elig_s   = cpu_req & ~pending_r;
        fifo_empty_s = (fifo_cnt_r == 2'd0);
        fifo_full_s  = (fifo_cnt_r == 2'd2);
        starved_s    = (starve_r >= STARVE_MAX);
        slot_s       = SLOT_IDLE;
        if (cpu_elig_s && (fifo_empty_s || starved_s)) begin
            slot_s = SLOT_CPU;
        end else if (!fifo_empty_s) begin
            slot_s = SLOT_VID;
        end else begin
            slot_s = SLOT_IDLE;
        end
    end

    // FIFO push/pop qualification; a push into a full FIFO is only legal
    // when the head is popped in the same cycle.
    always_comb begin
        pop_s     = (slot_s == SLOT_VID);
        push_ok_s = 1'b0;
        drop_s    = 1'b0;
        if (vid_req) begin
            if (fifo_full_s && !pop_s) begin
                drop_s = 1'b1;
            end else begin
                push_ok_s = 1'b1;
            end
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Next FIFO occupancy
    always_comb begin
        fifo_cnt_nxt_s = fifo_cnt_r;
        case ({push_ok_s, pop_s})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + 2'd1;
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - 2'd1;
            default: fifo_cnt_nxt_s = fifo_cnt_r;
        endcase
    end

    // Video FIFO storage, pointers and sticky overflow flag
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fifo_mem_r[0] <= {AW{1'b0}};
            fifo_mem_r[1] <= {AW{1'b0}};
            rd_ptr_r      <= 1'b0;
            wr_ptr_r      <= 1'b0;
            fifo_cnt_r    <= 2'd0;
            vid_ovf_r     <= 1'b0;
        end else begin
            // When full with a simultaneous pop, wr_ptr equals rd_ptr: the
            // head is read combinationally this cycle before being overwritten.
            if (push_ok_s) begin
                fifo_mem_r[wr_ptr_r] <= vid_addr;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            fifo_cnt_r <= fifo_cnt_nxt_s;
            if (drop_s) begin
                vid_ovf_r <= 1'b1;
            end
        end
    end

    // Starvation counter and CPU pending flag
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            starve_r  <= {SW{1'b0}};
            pending_r <= 1'b0;
        end else begin
            if (slot_s == SLOT_CPU) begin
                starve_r <= {SW{1'b0}};
            end else if ((slot_s == SLOT_VID) && cpu_elig_s && !starved_s) begin
                starve_r <= starve_r + {{(SW-1){1'b0}}, 1'b1};
            end
            // Pending stays high through the ack cycle so the still-asserted
            // cpu_req of the finished op is not mistaken for a new request.
            if (slot_s == SLOT_CPU) begin
                pending_r <= 1'b1;
            end else if (cpu_ack_r) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Issue stage: drive the VRAM port for the slot decided last cycle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mem_addr_r  <= {AW{1'b0}};
            mem_we_r    <= 1'b0;
            mem_wdata_r <= {DW{1'b0}};
            iss_vld_r   <= 1'b0;
            iss_cpu_r   <= 1'b0;
        end else begin
            case (slot_s)
                SLOT_CPU: begin
                    mem_addr_r <= cpu_addr;
                    mem_we_r   <= cpu_we;
                    if (cpu_we) begin
                        mem_wdata_r <= cpu_wdata;
                    end
                    iss_vld_r  <= 1'b1;
                    iss_cpu_r  <= 1'b1;
                end
                SLOT_VID: begin
                    mem_addr_r <= fifo_mem_r[rd_ptr_r];
                    mem_we_r   <= 1'b0;
                    iss_vld_r  <= 1'b1;
                    iss_cpu_r  <= 1'b0;
                end
                default: begin
                    // Idle: address holds, no strobe
                    mem_we_r   <= 1'b0;
                    iss_vld_r  <= 1'b0;
                    iss_cpu_r  <= 1'b0;
                end
            endcase
        end
    end

    // Return stage: remember who owns the data arriving on mem_rdata
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ret_vld_r <= 1'b0;
            ret_cpu_r <= 1'b0;
            ret_we_r  <= 1'b0;
        end else begin
            ret_vld_r <= iss_vld_r;
            ret_cpu_r <= iss_cpu_r;
            ret_we_r  <= mem_we_r;
        end
    end

    // Response registers: capture mem_rdata and pulse the owning side
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vid_valid_r <= 1'b0;
            vid_rdata_r <= {DW{1'b0}};
            cpu_ack_r   <= 1'b0;
            cpu_rdata_r <= {DW{1'b0}};
        end else begin
            vid_valid_r <= ret_vld_r & ~ret_cpu_r;
            cpu_ack_r   <= ret_vld_r & ret_cpu_r;
            if (ret_vld_r && !ret_cpu_r) begin
                vid_rdata_r <= mem_rdata;
            end
            // Writes ack without disturbing the last read value
            if (ret_vld_r && ret_cpu_r && !ret_we_r) begin
                cpu_rdata_r <= mem_rdata;
            end
        end
    end

`ifdef VGA_ARB_STATS_EN
    logic [15:0] stat_wait_r;

    // Count cycles the CPU asked, was not pending, and got no slot
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stat_wait_r <= 16'd0;
        end else if (cpu_req && !pending_r && (slot_s != SLOT_CPU)
                     && (stat_wait_r != 16'hFFFF)) begin
            stat_wait_r <= stat_wait_r + 16'd1;
        end
    end

    assign stat_wait = stat_wait_r;
`else
    assign stat_wait = 16'd0;
`endif

    assign mem_addr  = mem_addr_r;
    assign mem_we    = mem_we_r;
    assign mem_wdata = mem_wdata_r;
    assign vid_valid = vid_valid_r;
    assign vid_rdata = vid_rdata_r;
    assign vid_ovf   = vid_ovf_r;
    assign cpu_ack   = cpu_ack_r;
    assign cpu_rdata = cpu_rdata_r;

endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Shares one single-port video RAM between the VGA scanout fetch path and the AVR CPU bus.
- Video reads have priority. A starvation guard guarantees the CPU a slot.
- Video requests pass through a 2-entry FIFO, so a CPU slot can delay video without dropping it.
- Sits between the text-mode scanout/fetch logic and the VRAM block, in the `clock` domain.

Parameters:
- AW, 16, address width
- DW, 8, data width
- STARVE, 4, consecutive video-won cycles with CPU waiting before the CPU is forced a slot (≥1)

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- vid_req  in  1  single-cycle pulse: one video read
- vid_addr  in  AW  address for vid_req
- vid_valid  out  1  one-cycle pulse: vid_rdata valid
- vid_rdata  out  DW  video read data
- vid_ovf  out  1  sticky: a video request was dropped
- cpu_req  in  1  level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle pulse: CPU op complete
- cpu_rdata  out  DW  CPU read data (valid with cpu_ack on reads)
- mem_addr  out  AW  VRAM address (registered)
- mem_we  out  1  VRAM write strobe (registered)
- mem_wdata  out  DW  VRAM write data (registered)
- mem_rdata  in  DW  VRAM read data, valid the cycle after mem_addr is presented
- stat_wait  out  16  CPU wait statistic (see Optional Feature)

Behaviour:
- One clock, `clock`. Reset is synchronous, active-low on `reset_n`; all state updates on posedge `clock`.
- Reset values: all outputs 0. FIFO empty, starve counter 0, CPU pending flag 0, pipeline valid bits 0.
- Reset mid-operation discards in-flight ops: no vid_valid or cpu_ack after reset release for pre-reset requests.
- Video FIFO:
  - 2 entries of vid_addr; push on vid_req.
  - Push and pop in the same cycle are allowed, including when full.
  - Push while full with no pop: request dropped, vid_ovf ← 1 and held until reset.
- Slot decision: made each cycle from the registered FIFO state and registered arbiter state.
  - CPU eligible = cpu_req & !pending.
  - If CPU eligible and (FIFO empty or starve ≥ STARVE): CPU slot. Set pending, starve ← 0.
  - Else if FIFO non-empty: video slot, pop head. If CPU eligible, starve ← starve+1, saturating at STARVE.
  - Else: idle slot. mem_we=0, mem_addr holds its previous value.
- Issue: the slot decided in cycle N drives mem_addr/mem_we/mem_wdata in cycle N+1.
  - mem_we=1 only for a CPU write slot, for exactly one cycle.
- Return:
  - mem_rdata is valid in N+2 and is registered.
  - vid_valid or cpu_ack pulses in N+3. vid_rdata/cpu_rdata hold their value until the next pulse.
  - CPU writes also ack in N+3; cpu_rdata is unchanged on writes.
- Pending is cleared in the cycle cpu_ack pulses, so cpu_req is re-evaluated the cycle after ack.
  - The CPU master must drop or change its request on seeing ack; it may re-request immediately.
- cpu_req deasserted while pending: the op still completes and cpu_ack still pulses.
- Video latency, empty FIFO, no CPU contention: vid_req at cycle K → mem_addr at K+2 → vid_valid at K+4.
- Video results return in request order. vid_valid and cpu_ack are never high in the same cycle.

Optional Feature:
- Macro: VGA_ARB_STATS_EN.
- Defined:
  - stat_wait is a 16-bit saturating count (sticks at 0xFFFF) of cycles where cpu_req=1, pending=0 and no CPU slot was given.
  - Cleared only by reset.
- Not defined: stat_wait tied to 0 and no counter logic is synthesized.

Test Plan:
- Single video read: VRAM model returns addr[7:0]; vid_req at cycle 0, addr 0x0123 → mem_addr=0x0123 at cycle 2, vid_valid at cycle 4 with vid_rdata=0x23, vid_ovf=0.
- CPU write/read: write 0xA5 to 0x0010 → exactly one mem_we=1 cycle with mem_addr=0x0010, mem_wdata=0xA5, then cpu_ack. Read 0x0010 → cpu_ack with cpu_rdata=0xA5.
- Contention: vid_req every 2nd cycle plus cpu_req held → CPU granted within STARVE+1=5 cycles of eligibility, no vid_ovf, all video results returned in order.
- Overflow: vid_req every cycle, cpu_req held continuously → after the 2nd CPU slot the FIFO overflows, vid_ovf=1 and stays 1 until reset_n=0.
- Reset mid-op: reset_n low for 1 cycle while a CPU read is pending → no cpu_ack afterward, all outputs 0 during reset, next CPU read completes normally.
- Stats: with VGA_ARB_STATS_EN, the contention scenario gives stat_wait equal to the counted denied cycles (bench reference model). Without the macro, stat_wait=0 throughout.
